// File: rtl/fb_pkg.sv
// Shared types and constants for the 160x120x3 framebuffer and its scan-out.
package fb_pkg;

    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W = 15;

    typedef logic [7:0]           coord_x_t;
    typedef logic [6:0]           coord_y_t;
    typedef logic [2:0]           colour_t;
    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    localparam fb_addr_t FB_LAST = fb_addr_t'(FB_PIXELS - 1);

    // y*160 + x as shifts, all operands zero-extended to the full address width.
    function automatic fb_addr_t fb_addr(input coord_x_t x, input coord_y_t y);
        fb_addr_t xx;
        fb_addr_t yy;
        xx = {7'd0, x};
        yy = {8'd0, y};
        return (yy << 7) + (yy << 5) + xx;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// 19200x3 simple dual-port RAM: one write port, one registered read port,
// read-before-write on a same-address collision.
module fb_ram
    import fb_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [FB_ADDR_W-1:0] waddr,
    input  logic [2:0]           wdata,
    input  logic [FB_ADDR_W-1:0] raddr,
    output logic [2:0]           rdata
);

    colour_t mem [FB_PIXELS];

    // Both accesses in one non-blocking block: the read sees the pre-write value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// Plot-interface sink: stores pixels into the framebuffer, performs bulk
// clears, and streams the frame out in raster order.
module framebuffer_scanout
    import fb_pkg::*;
#(
    parameter int WIDTH    = FB_WIDTH,
    parameter int HEIGHT   = FB_HEIGHT,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          vga_x,
    input  logic [6:0]          vga_y,
    input  logic [COLOUR_W-1:0] vga_colour,
    input  logic                vga_plot,
    input  logic                clear,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic                clear_busy,
    input  logic                scan_en,
    output logic [7:0]          pix_x,
    output logic [6:0]          pix_y,
    output logic [COLOUR_W-1:0] pix_colour,
    output logic                pix_valid,
    output logic                frame_start
);

    localparam coord_x_t X_LIM  = coord_x_t'(WIDTH);
    localparam coord_y_t Y_LIM  = coord_y_t'(HEIGHT);
    localparam coord_x_t X_LAST = coord_x_t'(WIDTH - 1);
    localparam coord_y_t Y_LAST = coord_y_t'(HEIGHT - 1);

    fb_state_t state, state_d;
    fb_addr_t  fill_cnt, fill_cnt_d;
    colour_t   fill_colour, fill_colour_d;

    logic      we;
    fb_addr_t  waddr;
    colour_t   wdata;

    coord_x_t  sx;
    coord_y_t  sy;
    colour_t   rdata;

    // Write-port owner: the plot interface in RUN, the fill counter in CLEAR.
    always_comb begin
        state_d       = state;
        fill_cnt_d    = fill_cnt;
        fill_colour_d = fill_colour;
        we            = 1'b0;
        waddr         = fb_addr(vga_x, vga_y);
        wdata         = vga_colour;
        case (state)
            RUN: begin
                we = vga_plot && (vga_x < X_LIM) && (vga_y < Y_LIM);
                if (clear) begin
                    state_d       = CLEAR;
                    fill_cnt_d    = '0;
                    fill_colour_d = clear_colour;
                end
            end
            CLEAR: begin
                we         = 1'b1;
                waddr      = fill_cnt;
                wdata      = fill_colour;
                fill_cnt_d = fill_cnt + fb_addr_t'(1);
                if (fill_cnt == FB_LAST) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            fill_cnt    <= '0;
            fill_colour <= '0;
        end else begin
            state       <= state_d;
            fill_cnt    <= fill_cnt_d;
            fill_colour <= fill_colour_d;
        end
    end

    // The state register doubles as the externally visible busy flag.
    assign clear_busy = (state == CLEAR);

    // Scan contract: scan_en=1 issues (sx,sy) this cycle; exactly one cycle
    // later pix_valid=1 carries that pixel. No back-pressure exists: a beat
    // with pix_valid=1 must be consumed, and scan_en=0 simply stalls the raster.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx        <= '0;
            sy        <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= scan_en;
            pix_x     <= sx;
            pix_y     <= sy;
            if (scan_en) begin
                if (sx == X_LAST) begin
                    sx <= '0;
                    sy <= (sy == Y_LAST) ? '0 : sy + coord_y_t'(1);
                end else begin
                    sx <= sx + coord_x_t'(1);
                end
            end
        end
    end

    fb_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (fb_addr(sx, sy)),
        .rdata (rdata)
    );

    // RAM output is not reset, so it is masked outside valid beats.
    assign pix_colour  = pix_valid ? rdata : '0;
    assign frame_start = pix_valid && (pix_x == 8'd0) && (pix_y == 7'd0);

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout: plot table, clear timing, raster
// read-out with collision, stall and mid-fill reset sequences.
module tb_framebuffer_scanout;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] vga_x = '0;
    logic [6:0] vga_y = '0;
    logic [2:0] vga_colour = '0;
    logic       vga_plot = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] clear_colour = '0;
    logic       clear_busy;
    logic       scan_en = 1'b0;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_colour;
    logic       pix_valid;
    logic       frame_start;

    framebuffer_scanout dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .clear        (clear),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .scan_en      (scan_en),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_colour   (pix_colour),
        .pix_valid    (pix_valid),
        .frame_start  (frame_start)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [2:0] exp_mem [NPIX];
    bit         known   [NPIX];
    logic [2:0] cap     [NPIX];
    logic [2:0] exp_q[$];
    int         fs_pos[$];
    int         sx_m = 0;
    int         sy_m = 0;
    int         scan_errs;
    string      scan_first;
    logic [2:0] inj_old;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        bit         lands;
    } vec_t;
    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        sx_m = 0;
        sy_m = 0;
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic note(input string what);
        if (scan_errs == 0) scan_first = what;
        scan_errs++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        vga_x = x; vga_y = y; vga_colour = c; vga_plot = 1'b1;
        tick();
        vga_plot = 1'b0;
    endtask

    // Collect n valid beats; rnd toggles scan_en, inj>=0 plots (10,0)=5 on that beat's issue edge.
    task automatic scan(input int n, input string tag, input bit rnd, input int inj);
        int beats;
        int cycles;
        int a;
        beats = 0; cycles = 0; scan_errs = 0; scan_first = "";
        fs_pos.delete();
        while (beats < n && cycles < 4 * n + 100) begin
            scan_en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!rnd && beats == inj) begin
                vga_x = 8'd10; vga_y = 7'd0; vga_colour = 3'd5; vga_plot = 1'b1;
            end
            tick();
            vga_plot = 1'b0;
            cycles++;
            if (pix_valid !== scan_en) note($sformatf(" valid@%0d", cycles));
            if (pix_valid === 1'b1) begin
                a = sy_m * W + sx_m;
                if (pix_x !== sx_m[7:0] || pix_y !== sy_m[6:0])
                    note($sformatf(" coord@%0d got(%0d,%0d)", beats, pix_x, pix_y));
                if (known[a] && pix_colour !== exp_mem[a])
                    note($sformatf(" colour@(%0d,%0d) got %0d want %0d", sx_m, sy_m, pix_colour, exp_mem[a]));
                if (frame_start !== (sx_m == 0 && sy_m == 0))
                    note($sformatf(" frame_start@%0d", beats));
                if (frame_start === 1'b1) fs_pos.push_back(beats);
                cap[a] = pix_colour;
                if (!rnd && beats == inj) begin
                    inj_old = pix_colour;
                    exp_mem[10] = 3'd5;
                    known[10] = 1'b1;
                end
                sx_m++;
                if (sx_m == W) begin
                    sx_m = 0;
                    sy_m = (sy_m == H - 1) ? 0 : sy_m + 1;
                end
                beats++;
            end else if (frame_start !== 1'b0) begin
                note(" frame_start without valid");
            end
        end
        scan_en = 1'b0;
        check({tag, " beats"}, beats, n);
        check({tag, " errs", scan_first}, scan_errs, 0);
    endtask

    // Start a fill; with noise, plots and a second clear land mid-fill and must be ignored.
    task automatic do_clear(input logic [2:0] c, input bit noise);
        int len;
        clear_colour = c; clear = 1'b1;
        tick();
        clear = 1'b0; clear_colour = 3'd0;
        len = 0;
        while (clear_busy === 1'b1 && len < 20000) begin
            if (noise && len == 50) begin
                vga_x = 8'd20; vga_y = 7'd3; vga_colour = 3'd7; vga_plot = 1'b1;
            end
            if (noise && len == 9000) begin
                clear = 1'b1; clear_colour = 3'd7;
            end
            if (noise && len == 15000) begin
                vga_x = 8'd0; vga_y = 7'd0; vga_colour = 3'd5; vga_plot = 1'b1;
            end
            tick();
            vga_plot = 1'b0; clear = 1'b0; clear_colour = 3'd0;
            len++;
        end
        check("clear busy cycles", len, 19200);
        for (int a = 0; a < NPIX; a++) begin
            exp_mem[a] = c;
            known[a] = 1'b1;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{x: 8'd0,   y: 7'd0,   c: 3'd1, lands: 1'b1};
        vecs[1] = '{x: 8'd159, y: 7'd0,   c: 3'd4, lands: 1'b1};
        vecs[2] = '{x: 8'd0,   y: 7'd119, c: 3'd5, lands: 1'b1};
        vecs[3] = '{x: 8'd159, y: 7'd119, c: 3'd6, lands: 1'b1};
        vecs[4] = '{x: 8'd80,  y: 7'd60,  c: 3'd7, lands: 1'b1};
        vecs[5] = '{x: 8'd160, y: 7'd0,   c: 3'd7, lands: 1'b0};
        vecs[6] = '{x: 8'd0,   y: 7'd120, c: 3'd7, lands: 1'b0};
        vecs[7] = '{x: 8'd255, y: 7'd127, c: 3'd3, lands: 1'b0};
        vecs[8] = '{x: 8'd159, y: 7'd120, c: 3'd1, lands: 1'b0};
        vecs[9] = '{x: 8'd160, y: 7'd119, c: 3'd1, lands: 1'b0};
        for (int a = 0; a < NPIX; a++) known[a] = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset clear_busy", clear_busy, 0);
        check("reset pix_valid", pix_valid, 0);
        check("reset pix_x", pix_x, 0);
        check("reset pix_y", pix_y, 0);
        check("reset pix_colour", pix_colour, 0);
        check("reset frame_start", frame_start, 0);
        rst_n = 1'b1;
        tick();

        // Single plot read back on beat 7*160+5 = 1125
        plot(8'd5, 7'd7, 3'd3);
        exp_mem[1125] = 3'd3;
        known[1125] = 1'b1;
        scan(1126, "t1", 1'b0, -1);
        check("t1 pixel (5,7)", cap[1125], 3);
        reset_pulse();

        // Fill with 2; plots and a re-clear during the fill are dropped
        do_clear(3'd2, 1'b1);

        // Plot table, including out-of-range coordinates that must be dropped
        for (int i = 0; i < 10; i++) begin
            plot(vecs[i].x, vecs[i].y, vecs[i].c);
            if (vecs[i].lands) begin
                exp_mem[vecs[i].y * W + vecs[i].x] = vecs[i].c;
                exp_q.push_back(vecs[i].c);
            end
        end

        // Two full frames; (10,0) written on the edge it is read in frame 1
        scan(2 * NPIX, "frames", 1'b0, 10);
        check("collision old colour", inj_old, 2);
        check("collision new colour", cap[10], 5);
        check("frame_start count", fs_pos.size(), 2);
        check("frame_start first beat", (fs_pos.size() > 0) ? fs_pos[0] : -1, 0);
        check("frame_start spacing", (fs_pos.size() > 1) ? fs_pos[1] - fs_pos[0] : -1, NPIX);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].lands) begin
                check($sformatf("table plot (%0d,%0d)", vecs[i].x, vecs[i].y),
                      cap[vecs[i].y * W + vecs[i].x], exp_q.pop_front());
            end
        end
        check("dropped (160,0) not aliased to (0,1)", cap[160], 2);
        check("dropped fill plot (20,3)", cap[500], 2);

        // Stalled scan: same pixel order, nothing skipped
        scan(500, "stall", 1'b1, -1);
        check("stall frame_start at beat 0", (fs_pos.size() > 0) ? fs_pos[0] : -1, 0);

        // Reset after 100 fill writes aborts the fill
        clear_colour = 3'd6; clear = 1'b1;
        tick();
        clear = 1'b0; clear_colour = 3'd0;
        repeat (100) tick();
        check("abort busy before reset", clear_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy in reset", clear_busy, 0);
        check("abort pix_valid in reset", pix_valid, 0);
        #3;
        rst_n = 1'b1;
        tick();
        sx_m = 0;
        sy_m = 0;
        for (int a = 0; a < 100; a++) exp_mem[a] = 3'd6;
        check("abort busy after reset", clear_busy, 0);
        scan(200, "abort", 1'b0, -1);
        check("abort addr 99 filled", cap[99], 6);
        check("abort addr 100 kept", cap[100], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
